raster_scheduler: RTL
=====================

RASTER_SCHEDULER -- requirements
Module: raster_scheduler

Interface
REQ-001 Parameter WIDTH, default 320, framebuffer/z-buffer columns.
REQ-002 Parameter HEIGHT, default 240, framebuffer/z-buffer rows.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 areset  in  1  synchronous active-high reset, sampled on rising clk edge.
REQ-005 frame_start  in  1  one-cycle pulse; begin frame (clear, then render).
REQ-006 clear_color  in  4  background color; sampled on accepted frame_start.
REQ-007 tri_valid / tri_ready  in / out  1 / 1  triangle handshake.
REQ-008 tri_p1, tri_p2, tri_p3  in  3x32 each  vertices, raster coords, IEEE-754 single.
REQ-009 tri_color / tri_last  in  4 / 1  triangle color / last triangle of frame.
REQ-010 ru_start  out  1  one-cycle start pulse to rasterizer_unit.
REQ-011 ru_p1, ru_p2, ru_p3 / ru_color  out  3x32 each / 4  registered triangle to rasterizer_unit.
REQ-012 ru_done  in  1  rasterizer_unit completion pulse.
REQ-013 ru_fb_we, ru_fb_x, ru_fb_y, ru_fb_data  in  1,10,10,4  rasterizer framebuffer write.
REQ-014 ru_zb_we, ru_zb_x, ru_zb_y, ru_zb_wdata  in  1,10,10,6  rasterizer z-buffer write.
REQ-015 fb_we, fb_x, fb_y, fb_data  out  1,10,10,4  arbitrated framebuffer write port.
REQ-016 zb_we, zb_x, zb_y, zb_wdata  out  1,10,10,6  arbitrated z-buffer write port.
REQ-017 busy / frame_done / tri_count  out  1 / 1 / 16  frame in progress / one-cycle end pulse / triangles completed this frame.

Function
REQ-018 States SHALL be IDLE, CLEAR, WAIT_TRI, START, RASTER, FRAME_DONE; transitions on rising clk only.
REQ-019 IDLE: frame_start -> CLEAR; capture clear_color; zero clear counters and tri_count; frame_start SHALL be ignored in every other state.
REQ-020 CLEAR: each cycle fb_we=zb_we=1, fb_x=zb_x=cx, fb_y=zb_y=cy, fb_data=clear_color, zb_wdata=6'h3F.
REQ-021 CLEAR scan: cx increments; at cx=WIDTH-1, cx wraps to 0 and cy increments; after writing (WIDTH-1,HEIGHT-1) -> WAIT_TRI; exactly WIDTH*HEIGHT write cycles, first in cycle after frame_start.
REQ-022 WAIT_TRI: tri_ready=1 (Moore, this state only); tri_valid&tri_ready captures p1..p3, color, last -> START.
REQ-023 START: ru_start=1 for exactly one cycle, ru_p*/ru_color stable from capture until next capture -> RASTER.
REQ-024 RASTER: fb_*/zb_* SHALL combinationally pass through ru_fb_*/ru_zb_*; on ru_done tri_count+=1 (saturating at 16'hFFFF), then last ? FRAME_DONE : WAIT_TRI.
REQ-025 ru_done outside RASTER, including in START, SHALL be ignored.
REQ-026 FRAME_DONE: frame_done=1 one cycle -> IDLE; tri_count holds until next accepted frame_start.
REQ-027 busy=1 in every state except IDLE.
REQ-028 In IDLE, WAIT_TRI, START, FRAME_DONE: fb_we=zb_we=0; ru_fb_we/ru_zb_we dropped.
REQ-029 Triangle throughput: ru_done to next ru_start minimum 2 cycles (WAIT_TRI with tri_valid high, then START).

Reset
REQ-030 areset SHALL take priority over all inputs and force IDLE in the same edge, including mid-CLEAR or mid-RASTER.
REQ-031 After reset: busy, frame_done, ru_start, tri_ready, fb_we, zb_we = 0; tri_count, cx, cy, ru_p*, ru_color, fb/zb coords and data = 0.
REQ-032 Partially cleared buffers after reset mid-frame are NOT repaired; next frame_start performs full clear.

Verification (WIDTH=4, HEIGHT=3)
REQ-033 frame_start, clear_color=4'h5 -> 12 consecutive cycles fb_we=zb_we=1, coords (0,0),(1,0)..(3,2), fb_data=5, zb_wdata=3F; then tri_ready=1.
REQ-034 One triangle p1=(69,69,1) 428a0000/428a0000/3f800000, p2=(69,169,1), p3=(169,69,1), color=4'hA, last=1 -> ru_start one cycle after accept, ru_p* equal inputs; ru_done -> frame_done next cycle, tri_count=1, busy=0.
REQ-035 Three triangles, last on third, tri_valid held high -> three ru_start pulses, each exactly 2 cycles after previous ru_done; tri_count=3.
REQ-036 RASTER with ru_fb_we=1, ru_fb_x=7, ru_fb_data=3 -> fb_we=1, fb_x=7, fb_data=3 same cycle; identical stimulus in WAIT_TRI -> fb_we=0.
REQ-037 frame_start during RASTER and stray ru_done in WAIT_TRI -> no state change, tri_count unchanged.
REQ-038 areset asserted at 6th CLEAR cycle -> next cycle IDLE, fb_we=0, busy=0; new frame_start restarts clear at (0,0).

Source files
------------

// File: rtl/raster_scheduler.sv
// raster_scheduler: frame sequencer that clears buffers, feeds triangles to a rasterizer and arbitrates buffer writes
module raster_scheduler #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        frame_start,
    input  logic [3:0]  clear_color,
    input  logic        tri_valid,
    output logic        tri_ready,
    input  logic [95:0] tri_p1,
    input  logic [95:0] tri_p2,
    input  logic [95:0] tri_p3,
    input  logic [3:0]  tri_color,
    input  logic        tri_last,
    output logic        ru_start,
    output logic [95:0] ru_p1,
    output logic [95:0] ru_p2,
    output logic [95:0] ru_p3,
    output logic [3:0]  ru_color,
    input  logic        ru_done,
    input  logic        ru_fb_we,
    input  logic [9:0]  ru_fb_x,
    input  logic [9:0]  ru_fb_y,
    input  logic [3:0]  ru_fb_data,
    input  logic        ru_zb_we,
    input  logic [9:0]  ru_zb_x,
    input  logic [9:0]  ru_zb_y,
    input  logic [5:0]  ru_zb_wdata,
    output logic        fb_we,
    output logic [9:0]  fb_x,
    output logic [9:0]  fb_y,
    output logic [3:0]  fb_data,
    output logic        zb_we,
    output logic [9:0]  zb_x,
    output logic [9:0]  zb_y,
    output logic [5:0]  zb_wdata,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] tri_count
);
    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_TRI, START, RASTER, FRAME_DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  cx_q, cx_d, cy_q, cy_d;
    logic [3:0]  clr_q, clr_d;
    logic [95:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [3:0]  col_q, col_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_col, last_row, in_clear, in_raster;

    assign last_col  = cx_q == 10'(WIDTH - 1);
    assign last_row  = cy_q == 10'(HEIGHT - 1);
    assign in_clear  = state_q == CLEAR;
    assign in_raster = state_q == RASTER;

    // state register and captured frame/triangle context
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            clr_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            clr_q   <= clr_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            col_q   <= col_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state: clear scan, triangle capture and completion counting
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        clr_d   = clr_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
        col_d   = col_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = CLEAR;
                    clr_d   = clear_color;
                    cx_d    = '0;
                    cy_d    = '0;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cx_d = last_col ? 10'd0 : cx_q + 10'd1;
                cy_d = last_col ? cy_q + 10'd1 : cy_q;
                if (last_col && last_row)
                    state_d = WAIT_TRI;
            end
            WAIT_TRI: begin
                if (tri_valid) begin
                    state_d = START;
                    p1_d    = tri_p1;
                    p2_d    = tri_p2;
                    p3_d    = tri_p3;
                    col_d   = tri_color;
                    last_d  = tri_last;
                end
            end
            START:      state_d = RASTER;
            RASTER: begin
                if (ru_done) begin
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    state_d = last_q ? FRAME_DONE : WAIT_TRI;
                end
            end
            FRAME_DONE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    assign tri_ready  = state_q == WAIT_TRI;
    assign ru_start   = state_q == START;
    assign frame_done = state_q == FRAME_DONE;
    assign busy       = state_q != IDLE;
    assign tri_count  = cnt_q;
    assign ru_p1      = p1_q;
    assign ru_p2      = p2_q;
    assign ru_p3      = p3_q;
    assign ru_color   = col_q;

    assign fb_we    = in_clear | (in_raster & ru_fb_we);
    assign fb_x     = in_clear ? cx_q  : (in_raster ? ru_fb_x    : 10'd0);
    assign fb_y     = in_clear ? cy_q  : (in_raster ? ru_fb_y    : 10'd0);
    assign fb_data  = in_clear ? clr_q : (in_raster ? ru_fb_data : 4'd0);
    assign zb_we    = in_clear | (in_raster & ru_zb_we);
    assign zb_x     = in_clear ? cx_q  : (in_raster ? ru_zb_x     : 10'd0);
    assign zb_y     = in_clear ? cy_q  : (in_raster ? ru_zb_y     : 10'd0);
    assign zb_wdata = in_clear ? 6'h3F : (in_raster ? ru_zb_wdata : 6'd0);
endmodule
